// File: rtl/rot_imm_encoder.sv
// Rotate-immediate encoder: finds {rot, imm8} with ROR({24'b0, imm8}, 2*rot) == value.
// Latency: floor(r/STEPS_PER_CYCLE)+1 edges when found at r, 16/STEPS_PER_CYCLE when not found.
// Backpressure: accepts one value in IDLE only; holds the result in DONE until out_ready.
// Optional macro ROT_IMM_INVERT_EN adds a second search pass over ~value (MVN form).

module rot_imm_encoder #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_shifter,
  output logic        out_found,
  output logic        out_inverted
);

  // Only power-of-two group sizes that evenly divide the 16 candidates are supported.
  generate
    if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4 ||
          STEPS_PER_CYCLE == 8 || STEPS_PER_CYCLE == 16)) begin : g_bad_steps
      $error("rot_imm_encoder: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] val_q;
  logic [3:0]  rot_cnt;

`ifdef ROT_IMM_INVERT_EN
  logic        pass;
`endif

  logic        hit;
  logic [3:0]  hit_r;
  logic [7:0]  hit_imm;
  logic [3:0]  cand_r;
  logic [31:0] cand_rot;
  logic [4:0]  next_cnt;
  logic        last_grp;

  // Rotate left by an even amount; taking the top half of a doubled word avoids a 32-bit shift.
  function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] amt);
    logic [63:0] d;
    d = {v, v} << amt;
    return d[63:32];
  endfunction

  // Reset forces in_ready low even though the state register is already IDLE.
  assign in_ready = (state == IDLE) && !rst;

  // Carry out of the counter marks the final candidate group of this pass.
  assign next_cnt = {1'b0, rot_cnt} + 5'(STEPS_PER_CYCLE);
  assign last_grp = next_cnt[4];

  // Test the current candidate group; ascending order with a guard keeps the lowest rotation.
  always_comb begin
    hit      = 1'b0;
    hit_r    = '0;
    hit_imm  = '0;
    cand_r   = '0;
    cand_rot = '0;
    for (int k = 0; k < STEPS_PER_CYCLE; k++) begin
      cand_r   = rot_cnt + 4'(k);
      cand_rot = rol32(val_q, {cand_r, 1'b0});
      if (!hit && cand_rot[31:8] == 24'd0) begin
        hit     = 1'b1;
        hit_r   = cand_r;
        hit_imm = cand_rot[7:0];
      end
    end
  end

`ifndef ROT_IMM_INVERT_EN
  assign out_inverted = 1'b0;
`endif

  // Control FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      val_q        <= '0;
      rot_cnt      <= '0;
      out_valid    <= 1'b0;
      out_shifter  <= '0;
      out_found    <= 1'b0;
`ifdef ROT_IMM_INVERT_EN
      pass         <= 1'b0;
      out_inverted <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            val_q   <= in_value;
            rot_cnt <= '0;
`ifdef ROT_IMM_INVERT_EN
            pass    <= 1'b0;
`endif
            state   <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            out_shifter  <= {hit_r, hit_imm};
            out_found    <= 1'b1;
`ifdef ROT_IMM_INVERT_EN
            out_inverted <= pass;
`endif
            out_valid    <= 1'b1;
            state        <= DONE;
          end else if (!last_grp) begin
            rot_cnt <= next_cnt[3:0];
`ifdef ROT_IMM_INVERT_EN
          end else if (!pass) begin
            // Retry with the complement so the caller can emit MVN.
            pass    <= 1'b1;
            val_q   <= ~val_q;
            rot_cnt <= '0;
`endif
          end else begin
            out_shifter  <= '0;
            out_found    <= 1'b0;
`ifdef ROT_IMM_INVERT_EN
            out_inverted <= 1'b0;
`endif
            out_valid    <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
